// File: rtl/hamming_pkg.sv
// Shared constants and constant functions for the extended-Hamming SECDED codec.
// Positions are 1-based Hamming positions; position 0 holds the overall parity bit.
package hamming_pkg;

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_DOUBLE  = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    function automatic int calc_parity_bits(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    function automatic bit position_is_parity(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Hamming position of data bit j: the (j+1)-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int pos;
        int seen;
        pos  = 0;
        seen = 0;
        for (int i = 1; i < 128; i++) begin
            if (!position_is_parity(i)) begin
                if (seen == j && pos == 0) pos = i;
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED datapath: encode, syndrome/parity check, single-bit
// correction, data extraction and status classification.
module hamming_secded_core
    import hamming_pkg::*;
#(
    parameter int DATA_W  = 4,
    localparam int P_W    = calc_parity_bits(DATA_W),
    localparam int CODE_W = DATA_W + P_W + 1
) (
    input  logic              i_mode,
    input  logic [CODE_W-1:0] i_word,
    output logic [DATA_W-1:0] o_data,
    output logic [CODE_W-1:0] o_code,
    output logic [P_W-1:0]    o_syndrome,
    output logic [1:0]        o_status
);

    // Positions 1..CODE_W-1 whose index has bit k set.
    function automatic logic [CODE_W-1:0] cover_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 1; i < CODE_W; i++) m[i] = ((i >> k) & 1) != 0;
        return m;
    endfunction

    logic [CODE_W-1:0] w_placed;
    logic [CODE_W-1:0] w_enc;
    logic [CODE_W-1:0] w_corr;
    logic [P_W-1:0]    w_enc_par;
    logic [P_W-1:0]    w_syn;
    logic              w_pm;
    logic [1:0]        w_status;
    logic [DATA_W-1:0] w_ext;

    genvar gi;
    generate
        for (gi = 0; gi < P_W; gi++) begin : g_par
            localparam logic [CODE_W-1:0] COVER = cover_mask(gi);
            assign w_enc_par[gi] = ^(w_placed & COVER);
            assign w_syn[gi]     = ^(i_word & COVER);
        end
        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            assign w_ext[gi] = w_corr[data_pos(gi)];
        end
    endgenerate

    always_comb begin
        w_placed = '0;
        for (int j = 0; j < DATA_W; j++) w_placed[data_pos(j)] = i_word[j];
    end

    // w_placed[0] is zero, so the overall parity is over data and Hamming parity bits only.
    always_comb begin
        w_enc = w_placed;
        for (int k = 0; k < P_W; k++) w_enc[1 << k] = w_enc_par[k];
        w_enc[0] = (^w_placed) ^ (^w_enc_par);
    end

    assign w_pm = ^i_word;

    always_comb begin
        w_corr   = i_word;
        w_status = ST_CLEAN;
        if (w_syn == '0) begin
            if (w_pm) begin
                w_status  = ST_CORR;
                w_corr[0] = ~i_word[0];
            end
        end else if (!w_pm) begin
            w_status = ST_DOUBLE;
        end else if (int'(w_syn) <= CODE_W - 1) begin
            w_status = ST_CORR;
            w_corr   = i_word ^ (CODE_W'(1) << w_syn);
        end else begin
            w_status = ST_INVALID;
        end
    end

    assign o_data     = i_mode ? w_ext    : i_word[DATA_W-1:0];
    assign o_code     = i_mode ? w_corr   : w_enc;
    assign o_syndrome = i_mode ? w_syn    : '0;
    assign o_status   = i_mode ? w_status : ST_CLEAN;

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage valid/ready SECDED codec: S1 registers the request, S2 registers the
// core result. Saturating counters track corrected and uncorrectable decodes.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8,
    localparam int P_W    = calc_parity_bits(DATA_W),
    localparam int CODE_W = DATA_W + P_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [DATA_W-1:0] out_data,
    output logic [CODE_W-1:0] out_code,
    output logic [P_W-1:0]    out_syndrome,
    output logic [1:0]        out_status,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    input  logic              cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_s1_valid;
    logic              r_s1_mode;
    logic [CODE_W-1:0] r_s1_word;
    logic              r_s2_valid;
    logic              r_s2_mode;
    logic [DATA_W-1:0] r_s2_data;
    logic [CODE_W-1:0] r_s2_code;
    logic [P_W-1:0]    r_s2_syn;
    logic [1:0]        r_s2_status;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    logic              w_adv2;
    logic              w_dec_hs;
    logic [DATA_W-1:0] w_data;
    logic [CODE_W-1:0] w_code;
    logic [P_W-1:0]    w_syn;
    logic [1:0]        w_status;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_adv2;
    assign w_dec_hs = r_s2_valid && out_ready && r_s2_mode;

    hamming_secded_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_mode     (r_s1_mode),
        .i_word     (r_s1_word),
        .o_data     (w_data),
        .o_code     (w_code),
        .o_syndrome (w_syn),
        .o_status   (w_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_word  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= in_mode;
                r_s1_word <= in_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_s2_data   <= '0;
            r_s2_code   <= '0;
            r_s2_syn    <= '0;
            r_s2_status <= ST_CLEAN;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode   <= r_s1_mode;
                r_s2_data   <= w_data;
                r_s2_code   <= w_code;
                r_s2_syn    <= w_syn;
                r_s2_status <= w_status;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_dec_hs) begin
            if (r_s2_status == ST_CORR && r_corr_cnt != CNT_MAX)
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            if (r_s2_status[1] && r_uncorr_cnt != CNT_MAX)
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_mode     = r_s2_mode;
    assign out_data     = r_s2_data;
    assign out_code     = r_s2_code;
    assign out_syndrome = r_s2_syn;
    assign out_status   = r_s2_status;
    assign corr_cnt     = r_corr_cnt;
    assign uncorr_cnt   = r_uncorr_cnt;

endmodule
